adrv9001_enable_seq: RTL and testbench

- Parametrised enable sequencer for the ADRV9001 TX/RX enable pins; generalises the fixed tx1/tx2/rx1/rx2 enable wiring to NUM_CH channels.
- Each channel has programmable assert and deassert delays.
- Optional TX/RX mutual exclusion per port, plus a global abort.
- Sits between the software/DMA control registers and the adrv9001_*_en pads in the system top.

---
 rtl/adrv9001_enable_pkg.sv | 18 +
 rtl/adrv9001_enable_seq_if.sv | 25 ++
 rtl/adrv9001_enable_chan.sv | 120 ++++++++++++
 rtl/adrv9001_enable_seq.sv | 63 ++++++
 tb/tb_adrv9001_enable_seq.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adrv9001_enable_pkg.sv
// Shared types and helpers for the ADRV9001 enable sequencer.
package adrv9001_enable_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP_ON  = 2'd1,
        ST_ON       = 2'd2,
        ST_RAMP_OFF = 2'd3
    } chan_state_e;

    // Tie-break between partners that both leave IDLE in the same cycle: TX (even) wins.
    localparam bit EVEN_WINS = 1'b1;

    function automatic int unsigned dly_lsb(input int unsigned ch, input int unsigned dly_w);
        return ch * dly_w;
    endfunction

endpackage

// File: rtl/adrv9001_enable_seq_if.sv
// Control-register side and pad side of the enable sequencer, bundled per build.
interface adrv9001_enable_seq_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DLY_W  = 16
);
    logic [NUM_CH-1:0]       ch_req;
    logic [NUM_CH*DLY_W-1:0] ch_on_dly;
    logic [NUM_CH*DLY_W-1:0] ch_off_dly;
    logic                    abort;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_busy;
    logic [NUM_CH-1:0]       ch_en_rise;
    logic [NUM_CH-1:0]       ch_en_fall;
    logic [NUM_CH-1:0]       ch_blocked;

    modport master (
        output ch_req, ch_on_dly, ch_off_dly, abort,
        input  ch_en, ch_busy, ch_en_rise, ch_en_fall, ch_blocked
    );

    modport slave (
        input  ch_req, ch_on_dly, ch_off_dly, abort,
        output ch_en, ch_busy, ch_en_rise, ch_en_fall, ch_blocked
    );
endinterface

// File: rtl/adrv9001_enable_chan.sv
// One enable channel: IDLE/RAMP_ON/ON/RAMP_OFF sequencer with a down-counter.
module adrv9001_enable_chan
    import adrv9001_enable_pkg::*;
#(
    parameter int unsigned DLY_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             i_grant,
    input  logic             i_abort,
    input  logic [DLY_W-1:0] i_on_dly,
    input  logic [DLY_W-1:0] i_off_dly,
    output chan_state_e      o_state,
    output logic             o_en,
    output logic             o_busy,
    output logic             o_rise,
    output logic             o_fall
);

    chan_state_e      r_state;
    logic [DLY_W-1:0] r_cnt;
    logic             r_en;
    logic             r_busy;
    logic             r_rise;
    logic             r_fall;

    // Outputs are registered from the next state so ch_en tracks the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_en    <= 1'b0;
                r_busy  <= 1'b0;
                r_fall  <= r_en;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_req && i_grant) begin
                            if (i_on_dly == '0) begin
                                r_state <= ST_ON;
                                r_en    <= 1'b1;
                                r_rise  <= 1'b1;
                            end else begin
                                r_state <= ST_RAMP_ON;
                                r_cnt   <= i_on_dly - DLY_W'(1);
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_RAMP_ON: begin
                        if (!i_req) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_state <= ST_ON;
                            r_busy  <= 1'b0;
                            r_en    <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - DLY_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (!i_req) begin
                            if (i_off_dly == '0) begin
                                r_state <= ST_IDLE;
                                r_en    <= 1'b0;
                                r_fall  <= 1'b1;
                            end else begin
                                r_state <= ST_RAMP_OFF;
                                r_cnt   <= i_off_dly - DLY_W'(1);
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_RAMP_OFF: begin
                        // Re-request while ramping down keeps the pad enabled without a glitch.
                        if (i_req) begin
                            r_state <= ST_ON;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_en    <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - DLY_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_state = r_state;
    assign o_en    = r_en;
    assign o_busy  = r_busy;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/adrv9001_enable_seq.sv
// ADRV9001 TX/RX enable sequencer: NUM_CH channel FSMs plus per-port TX/RX exclusion.
module adrv9001_enable_seq
    import adrv9001_enable_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DLY_W     = 16,
    parameter bit          EXCLUSIVE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    adrv9001_enable_seq_if.slave bus
);

    chan_state_e       w_state [NUM_CH];
    logic [NUM_CH-1:0] w_idle;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_en;
    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_idle[i] = (w_state[i] == ST_IDLE);

        // Grant only when the partner sits in IDLE and is not leaving it this cycle.
        if (EXCLUSIVE) begin : g_excl
            if (i % 2 == 0) begin : g_even
                assign w_grant[i] = w_idle[i+1] &
                    ~(bus.ch_req[i+1] & ~bus.abort & ~EVEN_WINS);
            end else begin : g_odd
                assign w_grant[i] = w_idle[i-1] &
                    ~(bus.ch_req[i-1] & ~bus.abort & EVEN_WINS);
            end
        end else begin : g_indep
            assign w_grant[i] = 1'b1;
        end

        adrv9001_enable_chan #(
            .DLY_W (DLY_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_req     (bus.ch_req[i]),
            .i_grant   (w_grant[i]),
            .i_abort   (bus.abort),
            .i_on_dly  (bus.ch_on_dly[dly_lsb(i, DLY_W) +: DLY_W]),
            .i_off_dly (bus.ch_off_dly[dly_lsb(i, DLY_W) +: DLY_W]),
            .o_state   (w_state[i]),
            .o_en      (w_en[i]),
            .o_busy    (w_busy[i]),
            .o_rise    (w_rise[i]),
            .o_fall    (w_fall[i])
        );
    end

    assign bus.ch_en      = w_en;
    assign bus.ch_busy    = w_busy;
    assign bus.ch_en_rise = w_rise;
    assign bus.ch_en_fall = w_fall;
    assign bus.ch_blocked = bus.ch_req & w_idle & ~w_grant;

endmodule

// File: tb/tb_adrv9001_enable_seq.sv
// Bench for adrv9001_enable_seq: exclusive (A) and independent (B) builds, cycle-exact scoreboard.
module tb_adrv9001_enable_seq;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] busy;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] blk;
    } obs_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    obs_t sb_q[$];

    adrv9001_enable_seq_if #(.NUM_CH(4), .DLY_W(16)) ifa ();
    adrv9001_enable_seq_if #(.NUM_CH(4), .DLY_W(16)) ifb ();

    adrv9001_enable_seq #(.NUM_CH(4), .DLY_W(16), .EXCLUSIVE(1'b1)) u_dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    adrv9001_enable_seq #(.NUM_CH(4), .DLY_W(16), .EXCLUSIVE(1'b0)) u_dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs_a();
        return {ifa.ch_en, ifa.ch_busy, ifa.ch_en_rise, ifa.ch_en_fall, ifa.ch_blocked};
    endfunction

    function automatic obs_t obs_b();
        return {ifb.ch_en, ifb.ch_busy, ifb.ch_en_rise, ifb.ch_en_fall, ifb.ch_blocked};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("en=%b busy=%b rise=%b fall=%b blk=%b", o.en, o.busy, o.rise, o.fall, o.blk);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        ifa.ch_req = '0; ifb.ch_req = '0;
        ifa.abort = 1'b1; ifb.abort = 1'b1;
        tick();
        ifa.abort = 1'b0; ifb.abort = 1'b0;
        tick();
        tick();
        ifa.ch_on_dly = '0; ifa.ch_off_dly = '0;
        ifb.ch_on_dly = '0; ifb.ch_off_dly = '0;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t want;
        #3;
        sb_q.push_back('0);
        sb_q.push_back('0);
        got = obs_a(); want = sb_q.pop_front(); n_vec++;
        if (got !== want) begin
            n_err++; $display("FAIL reset_a got %s want %s", fmt(got), fmt(want));
        end
        got = obs_b(); want = sb_q.pop_front(); n_vec++;
        if (got !== want) begin
            n_err++; $display("FAIL reset_b got %s want %s", fmt(got), fmt(want));
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_ramp();
        obs_t e;
        obs_t got;
        obs_t want;
        ifa.ch_on_dly[0 +: 16] = 16'd10;
        for (int c = 0; c <= 5; c++) begin
            ifa.ch_req[0] = 1'b1;
            e = '0;
            e.busy[0] = (c >= 1);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL ramp_pre_rst c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        rst = 1'b1;
        sb_q.push_back('0);
        #1;
        got = obs_a(); want = sb_q.pop_front(); n_vec++;
        if (got !== want) begin
            n_err++; $display("FAIL async_rst got %s want %s", fmt(got), fmt(want));
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            e = '0;
            e.busy[0] = (c >= 1 && c <= 10);
            e.en[0]   = (c >= 11);
            e.rise[0] = (c == 11);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL ramp_post_rst c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_delay();
        obs_t e;
        obs_t got;
        obs_t want;
        ifa.ch_on_dly[16 +: 16]  = 16'd0;
        ifa.ch_off_dly[16 +: 16] = 16'd3;
        for (int c = 0; c <= 11; c++) begin
            ifa.ch_req[1] = (c < 5);
            e = '0;
            e.en[1]   = (c >= 1 && c < 9);
            e.rise[1] = (c == 1);
            e.fall[1] = (c == 9);
            e.busy[1] = (c >= 6 && c <= 8);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL delay c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_cancel();
        obs_t e;
        obs_t got;
        obs_t want;
        ifa.ch_on_dly[32 +: 16] = 16'd8;
        for (int c = 0; c <= 9; c++) begin
            ifa.ch_req[2] = (c < 4);
            e = '0;
            e.busy[2] = (c >= 1 && c <= 4);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL cancel c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_retrigger();
        obs_t e;
        obs_t got;
        obs_t want;
        ifa.ch_on_dly[32 +: 16]  = 16'd0;
        ifa.ch_off_dly[32 +: 16] = 16'd8;
        for (int c = 0; c <= 17; c++) begin
            ifa.ch_req[2] = (c < 5) || (c >= 8 && c < 15);
            // final drop uses a zero off-delay
            if (c == 15) ifa.ch_off_dly[32 +: 16] = 16'd0;
            e = '0;
            e.en[2]   = (c >= 1 && c < 16);
            e.rise[2] = (c == 1);
            e.fall[2] = (c == 16);
            e.busy[2] = (c >= 6 && c <= 8);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL retrigger c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_exclusion();
        obs_t e;
        obs_t got;
        obs_t want;
        ifa.ch_on_dly[0 +: 16]   = 16'd3;
        ifa.ch_off_dly[0 +: 16]  = 16'd2;
        ifa.ch_on_dly[16 +: 16]  = 16'd2;
        ifa.ch_off_dly[16 +: 16] = 16'd0;
        for (int c = 0; c <= 13; c++) begin
            ifa.ch_req[0] = (c <= 5);
            ifa.ch_req[1] = 1'b1;
            e = '0;
            e.busy[0] = (c >= 1 && c <= 3) || (c >= 7 && c <= 8);
            e.en[0]   = (c >= 4 && c <= 8);
            e.rise[0] = (c == 4);
            e.fall[0] = (c == 9);
            e.blk[1]  = (c <= 8);
            e.busy[1] = (c >= 10 && c <= 11);
            e.en[1]   = (c >= 12);
            e.rise[1] = (c == 12);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL exclusion c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_abort();
        obs_t e;
        obs_t got;
        obs_t want;
        ifa.ch_on_dly[0 +: 16]  = 16'd0;
        ifa.ch_on_dly[48 +: 16] = 16'd6;
        for (int c = 0; c <= 17; c++) begin
            ifa.ch_req[0] = 1'b1;
            ifa.ch_req[3] = 1'b1;
            ifa.abort = (c == 3) || (c >= 13 && c <= 15);
            e = '0;
            e.en[0]   = (c >= 1 && c <= 3) || (c >= 5 && c <= 13) || (c >= 17);
            e.rise[0] = (c == 1) || (c == 5) || (c == 17);
            e.fall[0] = (c == 4) || (c == 14);
            e.busy[3] = (c >= 1 && c <= 3) || (c >= 5 && c <= 10) || (c >= 17);
            e.en[3]   = (c >= 11 && c <= 13);
            e.rise[3] = (c == 11);
            e.fall[3] = (c == 14);
            sb_q.push_back(e);
            #1;
            got = obs_a(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL abort c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_no_exclusive();
        obs_t e;
        obs_t got;
        obs_t want;
        ifb.ch_on_dly[0 +: 16]  = 16'd2;
        ifb.ch_on_dly[16 +: 16] = 16'd5;
        for (int c = 0; c <= 8; c++) begin
            ifb.ch_req[0] = 1'b1;
            ifb.ch_req[1] = 1'b1;
            e = '0;
            e.busy[0] = (c >= 1 && c <= 2);
            e.en[0]   = (c >= 3);
            e.rise[0] = (c == 3);
            e.busy[1] = (c >= 1 && c <= 5);
            e.en[1]   = (c >= 6);
            e.rise[1] = (c == 6);
            sb_q.push_back(e);
            #1;
            got = obs_b(); want = sb_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL no_excl c=%0d got %s want %s", c, fmt(got), fmt(want));
            end
            tick();
        end
        quiesce();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_vec = 0;
        n_err = 0;
        ifa.ch_req = '0; ifa.ch_on_dly = '0; ifa.ch_off_dly = '0; ifa.abort = 1'b0;
        ifb.ch_req = '0; ifb.ch_on_dly = '0; ifb.ch_off_dly = '0; ifb.abort = 1'b0;
        test_reset();
        test_reset_mid_ramp();
        test_delay();
        test_cancel();
        test_retrigger();
        test_exclusion();
        test_abort();
        test_no_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
